tl_phase_sched: RTL and testbench

- Timed phase scheduler for the four-way traffic light with left-turn phases.
- Sequences the 3-bit eight-state phase register (A green, A yellow, A left, A left-yellow, B green, B yellow, B left, B left-yellow).
- Adds a per-phase cycle timer enforcing minimum green, maximum green and fixed yellow durations.
- Skips left-turn phases with no waiting traffic; drives both light heads directly. Top-level controller for the intersection.

---
 rtl/tl_phase_sched.sv | 118 +++++++++++
 tb/tb_tl_phase_sched.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_phase_sched.sv
// Timed phase scheduler for a four-way intersection with left-turn phases.
// Sequences eight phases under min/max green and fixed yellow timing.
module tl_phase_sched #(
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 16,
    parameter int YELLOW    = 2,
    parameter int CNT_W     = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             ta,
    input  logic             tal,
    input  logic             tb,
    input  logic             tbl,
    output logic [1:0]       la,
    output logic [1:0]       lb,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] tmr,
    output logic             phase_chg
);

    typedef enum logic [2:0] {
        AG  = 3'd0,
        AY  = 3'd1,
        AL  = 3'd2,
        ALY = 3'd3,
        BG  = 3'd4,
        BY  = 3'd5,
        BL  = 3'd6,
        BLY = 3'd7
    } phase_e;

    localparam logic [CNT_W-1:0] MIN_M1 = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_M1 = CNT_W'(YELLOW - 1);

    phase_e           state_q, state_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic             chg_q, chg_d;
    logic             sense;
    logic             exit_c;
    phase_e           nxt;

    // Sensor of the current hold phase and the phase that follows this one
    always_comb begin
        sense = 1'b0;
        nxt   = AG;
        unique case (state_q)
            AG:  begin sense = ta;  nxt = AY; end
            AY:  nxt = tal ? AL : BG;
            AL:  begin sense = tal; nxt = ALY; end
            ALY: nxt = BG;
            BG:  begin sense = tb;  nxt = BY; end
            BY:  nxt = tbl ? BL : AG;
            BL:  begin sense = tbl; nxt = BLY; end
            BLY: nxt = AG;
        endcase
    end

    // Exit test: odd phases are yellow, even phases hold on their sensor
    always_comb begin
        if (state_q[0])
            exit_c = (tmr_q == YEL_M1);
        else
            exit_c = ((tmr_q >= MIN_M1) && !sense) || (tmr_q == MAX_M1);
    end

    // Next phase, timer and change pulse; a low enable freezes everything
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        chg_d   = 1'b0;
        if (en) begin
            if (exit_c) begin
                state_d = nxt;
                tmr_d   = '0;
                chg_d   = 1'b1;
            end else begin
                tmr_d = tmr_q + CNT_W'(1);
            end
        end
    end

    // Phase, timer and change-pulse registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= AG;
            tmr_q   <= '0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            chg_q   <= chg_d;
        end
    end

    // Light heads decoded from the phase alone
    always_comb begin
        la = 2'b11;
        lb = 2'b11;
        unique case (state_q)
            AG:  la = 2'b00;
            AY:  la = 2'b01;
            AL:  la = 2'b10;
            ALY: la = 2'b01;
            BG:  lb = 2'b00;
            BY:  lb = 2'b01;
            BL:  lb = 2'b10;
            BLY: lb = 2'b01;
        endcase
    end

    assign state     = state_q;
    assign tmr       = tmr_q;
    assign phase_chg = chg_q;

endmodule

// File: tb/tb_tl_phase_sched.sv
// Directed bench for tl_phase_sched with default timing parameters.
// Each task drives one scenario and checks against hand-derived values.
module tb_tl_phase_sched;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic       ta, tal, tb, tbl;
    logic [1:0] la, lb;
    logic [2:0] state;
    logic [4:0] tmr;
    logic       phase_chg;

    int errors = 0;
    int checks = 0;

    tl_phase_sched #(
        .MIN_GREEN(4),
        .MAX_GREEN(16),
        .YELLOW(2),
        .CNT_W(5)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .en(en),
        .ta(ta),
        .tal(tal),
        .tb(tb),
        .tbl(tbl),
        .la(la),
        .lb(lb),
        .state(state),
        .tmr(tmr),
        .phase_chg(phase_chg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input logic [2:0] s, input logic [4:0] t);
        int n;
        n = 0;
        while (!(state === s && tmr === t) && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (state !== s || tmr !== t) begin
            errors++;
            $display("FAIL run_to: state=%0d tmr=%0d, wanted state=%0d tmr=%0d",
                     state, tmr, s, t);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        en = 1'b0;
        ta = 0; tal = 0; tb = 0; tbl = 0;
        #2;
        checks++;
        if (state !== 3'd0 || tmr !== 5'd0 || phase_chg !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: state=%0d tmr=%0d chg=%0d, wanted 0 0 0",
                     state, tmr, phase_chg);
        end
        checks++;
        if (la !== 2'b00 || lb !== 2'b11) begin
            errors++;
            $display("FAIL reset_lights: la=%b lb=%b, wanted 00 11", la, lb);
        end
        tick();
        reset_n = 1'b1;
        en = 1'b1;
    endtask

    task automatic test_default_cycle();
        logic [2:0] st [12];
        logic [4:0] tm [12];
        logic       ch [12];
        logic [1:0] ela [8];
        logic [1:0] elb [8];
        int p;
        st  = '{3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1,
                3'd1, 3'd4, 3'd4, 3'd4, 3'd5, 3'd5};
        st[0] = 3'd0;
        st[4] = 3'd1;
        st[5] = 3'd1;
        st[6] = 3'd4;
        tm  = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd1,
                5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd1};
        ch  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        ela = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11};
        elb = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b01, 2'b10, 2'b01};
        for (int k = 1; k <= 24; k++) begin
            tick();
            p = k % 12;
            checks++;
            if (state !== st[p] || tmr !== tm[p] || phase_chg !== ch[p]) begin
                errors++;
                $display("FAIL default_cycle k=%0d: st=%0d tmr=%0d chg=%0d, wanted %0d %0d %0d",
                         k, state, tmr, phase_chg, st[p], tm[p], ch[p]);
            end
            checks++;
            if (la !== ela[st[p]] || lb !== elb[st[p]]) begin
                errors++;
                $display("FAIL default_lights k=%0d: la=%b lb=%b, wanted %b %b",
                         k, la, lb, ela[st[p]], elb[st[p]]);
            end
        end
    endtask

    task automatic test_max_green();
        ta = 1'b1;
        repeat (15) tick();
        checks++;
        if (state !== 3'd0 || tmr !== 5'd15) begin
            errors++;
            $display("FAIL max_green_hold: st=%0d tmr=%0d, wanted 0 15", state, tmr);
        end
        tick();
        checks++;
        if (state !== 3'd1 || tmr !== 5'd0 || phase_chg !== 1'b1) begin
            errors++;
            $display("FAIL max_green_exit: st=%0d tmr=%0d chg=%0d, wanted 1 0 1",
                     state, tmr, phase_chg);
        end
        ta = 1'b0;
    endtask

    task automatic test_ta_drop();
        run_to(3'd0, 5'd0);
        ta = 1'b1;
        repeat (7) tick();
        checks++;
        if (state !== 3'd0 || tmr !== 5'd7) begin
            errors++;
            $display("FAIL ta_drop_hold: st=%0d tmr=%0d, wanted 0 7", state, tmr);
        end
        ta = 1'b0;
        tick();
        checks++;
        if (state !== 3'd1 || tmr !== 5'd0) begin
            errors++;
            $display("FAIL ta_drop_exit: st=%0d tmr=%0d, wanted 1 0", state, tmr);
        end
    endtask

    task automatic test_left_turns();
        run_to(3'd1, 5'd1);
        tal = 1'b1;
        tick();
        tal = 1'b0;
        checks++;
        if (state !== 3'd2 || tmr !== 5'd0 || la !== 2'b10 || lb !== 2'b11) begin
            errors++;
            $display("FAIL a_left_enter: st=%0d tmr=%0d la=%b lb=%b, wanted 2 0 10 11",
                     state, tmr, la, lb);
        end
        repeat (3) tick();
        checks++;
        if (state !== 3'd2 || tmr !== 5'd3) begin
            errors++;
            $display("FAIL a_left_last: st=%0d tmr=%0d, wanted 2 3", state, tmr);
        end
        tick();
        checks++;
        if (state !== 3'd3 || tmr !== 5'd0 || la !== 2'b01) begin
            errors++;
            $display("FAIL a_left_yel: st=%0d tmr=%0d la=%b, wanted 3 0 01", state, tmr, la);
        end
        repeat (2) tick();
        checks++;
        if (state !== 3'd4 || tmr !== 5'd0 || lb !== 2'b00 || la !== 2'b11) begin
            errors++;
            $display("FAIL a_left_to_bg: st=%0d tmr=%0d la=%b lb=%b, wanted 4 0 11 00",
                     state, tmr, la, lb);
        end
        run_to(3'd5, 5'd1);
        tbl = 1'b1;
        tick();
        tbl = 1'b0;
        checks++;
        if (state !== 3'd6 || tmr !== 5'd0 || lb !== 2'b10 || la !== 2'b11) begin
            errors++;
            $display("FAIL b_left_enter: st=%0d tmr=%0d la=%b lb=%b, wanted 6 0 11 10",
                     state, tmr, la, lb);
        end
        repeat (4) tick();
        checks++;
        if (state !== 3'd7 || tmr !== 5'd0 || lb !== 2'b01) begin
            errors++;
            $display("FAIL b_left_yel: st=%0d tmr=%0d lb=%b, wanted 7 0 01", state, tmr, lb);
        end
        repeat (2) tick();
        checks++;
        if (state !== 3'd0 || tmr !== 5'd0 || la !== 2'b00) begin
            errors++;
            $display("FAIL b_left_to_ag: st=%0d tmr=%0d la=%b, wanted 0 0 00", state, tmr, la);
        end
    endtask

    task automatic test_enable();
        run_to(3'd0, 5'd2);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (state !== 3'd0 || tmr !== 5'd2 || la !== 2'b00 || phase_chg !== 1'b0) begin
                errors++;
                $display("FAIL en_freeze i=%0d: st=%0d tmr=%0d la=%b chg=%0d, wanted 0 2 00 0",
                         i, state, tmr, la, phase_chg);
            end
        end
        en = 1'b1;
        tick();
        checks++;
        if (state !== 3'd0 || tmr !== 5'd3) begin
            errors++;
            $display("FAIL en_resume: st=%0d tmr=%0d, wanted 0 3", state, tmr);
        end
        tick();
        checks++;
        if (state !== 3'd1 || tmr !== 5'd0 || phase_chg !== 1'b1) begin
            errors++;
            $display("FAIL en_exit: st=%0d tmr=%0d chg=%0d, wanted 1 0 1", state, tmr, phase_chg);
        end
    endtask

    task automatic test_reset_mid();
        tb = 1'b1;
        run_to(3'd4, 5'd5);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (state !== 3'd0 || tmr !== 5'd0 || la !== 2'b00 || lb !== 2'b11 ||
            phase_chg !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: st=%0d tmr=%0d la=%b lb=%b chg=%0d, wanted 0 0 00 11 0",
                     state, tmr, la, lb, phase_chg);
        end
        #2;
        reset_n = 1'b1;
        tb = 1'b0;
        tick();
        checks++;
        if (state !== 3'd0 || tmr !== 5'd1) begin
            errors++;
            $display("FAIL reset_release: st=%0d tmr=%0d, wanted 0 1", state, tmr);
        end
    endtask

    initial begin
        test_reset();
        test_default_cycle();
        test_max_green();
        test_ta_drop();
        test_left_turns();
        test_enable();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
